// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings
// (matching funct[1:0] used by the decoder), default latencies, FSM state
// type, the packed {hi, lo} result type and a small op-class helper.
package mult_div_unit_pkg;

    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_MULTU = 2'b01;
    localparam logic [1:0] MDU_OP_DIV   = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mduState_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mduResult_t;

    // Divide ops are the upper half of the encoding space.
    function automatic logic mduIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bus between the decode-stage start controller (master) and the
// multiply/divide unit (slave).
//   Start/Op/D1/D2 : launch an operation (one-cycle pulse)
//   WeHi/WeLo      : MTHI/MTLO writes of D1
//   Busy/HI/LO     : unit status and architectural HI/LO
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        Start;
    logic [1:0]  Op;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        WeHi;
    logic        WeLo;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, Op, D1, D2, WeHi, WeLo, input Busy, HI, LO);
    modport slave  (input Start, Op, D1, D2, WeHi, WeLo, output Busy, HI, LO);

endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational datapath of the multiply/divide unit.
//   Op     in  operation select (MULT/MULTU/DIV/DIVU)
//   D1, D2 in  rs / rt operands
//   result out {hi, lo} for the selected operation
//   div0   out divide op with a zero divisor (result must not be committed)
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [1:0]  Op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output mduResult_t  result,
    output logic        div0
);

    logic signed [63:0] sProd_s;
    logic [63:0]        uProd_s;
    logic               zeroDiv_s;
    logic               sOvf_s;
    logic [31:0]        sDivisor_s;
    logic [31:0]        uDivisor_s;
    logic signed [31:0] sQuot_s;
    logic signed [31:0] sRem_s;
    logic [31:0]        uQuot_s;
    logic [31:0]        uRem_s;

    assign sProd_s   = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    assign uProd_s   = {32'd0, D1} * {32'd0, D2};
    assign zeroDiv_s = (D2 == 32'd0);
    assign sOvf_s    = (D1 == 32'h8000_0000) && (D2 == 32'hFFFF_FFFF);

    // Substitute a harmless divisor for the cases whose result is forced or
    // discarded, so the dividers never see /0 or the signed overflow.
    assign sDivisor_s = (zeroDiv_s || sOvf_s) ? 32'd1 : D2;
    assign uDivisor_s = zeroDiv_s ? 32'd1 : D2;

    assign sQuot_s = $signed(D1) / $signed(sDivisor_s);
    assign sRem_s  = $signed(D1) % $signed(sDivisor_s);
    assign uQuot_s = D1 / uDivisor_s;
    assign uRem_s  = D1 % uDivisor_s;

    // Select the result for the requested operation.
    always_comb begin
        result = 64'd0;
        div0   = 1'b0;
        case (Op)
            MDU_OP_MULT:  result = sProd_s;
            MDU_OP_MULTU: result = uProd_s;
            MDU_OP_DIV: begin
                div0 = zeroDiv_s;
                if (sOvf_s) begin
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {sRem_s, sQuot_s};
                end
            end
            MDU_OP_DIVU: begin
                div0   = zeroDiv_s;
                result = {uRem_s, uQuot_s};
            end
            default: begin
                result = 64'd0;
                div0   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit (E stage).
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-high reset
//   bus   slave side of mult_div_unit_if:
//         Start/Op/D1/D2 launch, WeHi/WeLo MTHI/MTLO, Busy/HI/LO outputs
// The result is computed combinationally at Start and held in a pending
// register; Busy is then held for a fixed latency before HI/LO commit.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
)
(
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    mduState_e       state_r;
    logic [CntW-1:0] cnt_r;
    mduResult_t      pend_r;
    logic            pendDiv0_r;
    logic            busy_r;
    logic [31:0]     hi_r;
    logic [31:0]     lo_r;
    mduResult_t      arithRes_s;
    logic            arithDiv0_s;

    mdu_arith uArith (
        .Op     (bus.Op),
        .D1     (bus.D1),
        .D2     (bus.D2),
        .result (arithRes_s),
        .div0   (arithDiv0_s)
    );

    assign bus.Busy = busy_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;

    // Control FSM, latency counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= MDU_IDLE;
            cnt_r      <= '0;
            pend_r     <= 64'd0;
            pendDiv0_r <= 1'b0;
            busy_r     <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    // Start takes priority; a coincident MT write is dropped.
                    if (bus.Start) begin
                        pend_r     <= arithRes_s;
                        pendDiv0_r <= arithDiv0_s;
                        cnt_r      <= mduIsDiv(bus.Op) ? DivLoad : MultLoad;
                        busy_r     <= 1'b1;
                        state_r    <= MDU_RUN;
                    end else begin
                        if (bus.WeHi) begin
                            hi_r <= bus.D1;
                        end
                        if (bus.WeLo) begin
                            lo_r <= bus.D1;
                        end
                    end
                end
                MDU_RUN: begin
                    // Start and MT writes are ignored here; counter reaching
                    // one marks the edge that ends the last Busy cycle.
                    cnt_r <= cnt_r - CntOne;
                    if (cnt_r == CntOne) begin
                        if (!pendDiv0_r) begin
                            hi_r <= pend_r.hi;
                            lo_r <= pend_r.lo;
                        end
                        busy_r  <= 1'b0;
                        state_r <= MDU_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= MDU_IDLE;
                end
            endcase
        end
    end

endmodule
